// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: sequences a 16-bit async SRAM for the MEM stage, one 32-bit access as two halfword phases (low half first).
// Latency: request seen in cycle 0, ready=1 in cycle 2*WAIT_CYCLES+1 (DONE), back in IDLE the cycle after.
// Backpressure: ready is low while a request is pending and not yet completing; the pipeline freezes on ~ready.
//
// Optional feature macro: SRAM_STALL_CNT_EN adds output stall_cycles (saturating count of clocks with ready==0).
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   rd_en, wr_en      level requests from MEM (write wins if both set)
//   address           byte address; SRAM word = (address-ADDR_BASE)>>2, truncated
//   write_data        store data, latched at acceptance
//   read_data         load result, updated only on a read's capture edges
//   ready             combinational: no request pending, or access completing this cycle
//   SRAM_*            SRAM address, bidirectional data and active-low strobes (all registered)
module sram_access_ctrl #(
  parameter int ADDR_BASE   = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 18,
  parameter int SRAM_DW     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
`ifdef SRAM_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Index of the last cycle of a halfword phase.
  localparam logic [3:0] LP_LAST = 4'(WAIT_CYCLES - 1);

  state_t             r_state;
  logic [3:0]         r_cnt;
  logic               r_is_wr;
  logic [SRAM_AW-2:0] r_word;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic [SRAM_AW-1:0] r_addr;
  logic               r_we_n;
  logic               r_oe_n;
  logic               r_ce_n;
  logic               r_be_n;
  logic               r_dq_oe;
  logic [15:0]        r_dq_out;

  logic [SRAM_AW-2:0] w_word;
  logic               w_req;
  logic               w_last;

  // Addresses below the base wrap silently through the truncation.
  assign w_word = (SRAM_AW-1)'((address - 32'(ADDR_BASE)) >> 2);
  assign w_req  = rd_en | wr_en;
  assign w_last = (r_cnt == LP_LAST);

  assign ready = ~w_req | (r_state == ST_DONE);

  assign read_data = r_rdata;
  assign SRAM_ADDR = r_addr;
  assign SRAM_WE_N = r_we_n;
  assign SRAM_OE_N = r_oe_n;
  assign SRAM_CE_N = r_ce_n;
  assign SRAM_UB_N = r_be_n;
  assign SRAM_LB_N = r_be_n;
  assign SRAM_DQ   = r_dq_oe ? r_dq_out : {SRAM_DW{1'bz}};

  // Strobes are set up on the edge that enters a phase, so each output is a
  // plain flop and the SRAM never sees decode glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_is_wr  <= 1'b0;
      r_word   <= '0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_addr   <= '0;
      r_we_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_ce_n   <= 1'b1;
      r_be_n   <= 1'b1;
      r_dq_oe  <= 1'b0;
      r_dq_out <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_is_wr  <= wr_en;
            r_word   <= w_word;
            r_wdata  <= write_data;
            r_cnt    <= 4'd0;
            r_addr   <= {w_word, 1'b0};
            r_ce_n   <= 1'b0;
            r_be_n   <= 1'b0;
            r_we_n   <= ~wr_en;
            r_oe_n   <= wr_en;
            r_dq_oe  <= wr_en;
            r_dq_out <= write_data[15:0];
            r_state  <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (w_last) begin
            if (!r_is_wr) begin
              r_rdata[15:0] <= SRAM_DQ[15:0];
            end
            r_cnt    <= 4'd0;
            r_addr   <= {r_word, 1'b1};
            r_dq_out <= r_wdata[31:16];
            r_state  <= ST_HIGH;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_HIGH: begin
          if (w_last) begin
            if (!r_is_wr) begin
              r_rdata[31:16] <= SRAM_DQ[15:0];
            end
            r_cnt   <= 4'd0;
            r_ce_n  <= 1'b1;
            r_be_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_dq_oe <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_DONE: begin
          // A request still held next cycle is accepted as a fresh access.
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SRAM_STALL_CNT_EN
  logic [31:0] r_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall <= 32'd0;
    end else if (!ready && (r_stall != 32'hFFFF_FFFF)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: directed scenarios plus randomized accesses checked
// against a word-level reference memory and the phase timing rules.
module tb_sram_access_ctrl;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        we_n, oe_n, ce_n, ub_n, lb_n;
  logic        probe_en;
`ifdef SRAM_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_access_ctrl #(
    .ADDR_BASE(1024), .WAIT_CYCLES(W), .SRAM_AW(18), .SRAM_DW(16)
  ) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
    .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
`ifdef SRAM_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  // Power-up contents of the SRAM, so unwritten locations still read back distinct data.
  function automatic logic [15:0] init_pat(input logic [17:0] a);
    return a[15:0] ^ {a[17:16], 14'h0} ^ 16'hC3A5;
  endfunction

  // Behavioural async SRAM: storage kept XOR-ed with the power-up pattern.
  bit   [15:0] sram_mem [0:262143];
  logic [15:0] sram_rd;
  assign sram_rd = sram_mem[sram_addr] ^ init_pat(sram_addr);
  assign sram_dq = (!ce_n && !oe_n && we_n) ? sram_rd : 16'bz;
  // Probe driver: reads back A5A5 only if the controller has released the bus.
  assign sram_dq = probe_en ? 16'hA5A5 : 16'bz;
  always @(posedge clk) begin
    if (!ce_n && !we_n) sram_mem[sram_addr] <= sram_dq ^ init_pat(sram_addr);
  end

  // Reference memory: halfword index -> data, filled by completed writes.
  logic [15:0] ref_mem [int];

  function automatic logic [15:0] ref_half(input int hw);
    if (ref_mem.exists(hw)) return ref_mem[hw];
    return init_pat(18'(hw));
  endfunction

  // Halfword index of the low half: word = ((addr - base) mod 2^32) / 4 mod 2^17.
  function automatic int hw_of(input logic [31:0] a);
    longint off;
    off = (longint'(a) - 64'd1024) & 64'hFFFF_FFFF;
    return int'((off / 4) % 131072) * 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rd_en = 0; wr_en = 0; address = 0; write_data = 0; probe_en = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({we_n, oe_n, ce_n, ub_n, lb_n} !== 5'b11111) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 11111", {we_n, oe_n, ce_n, ub_n, lb_n});
    end
    n_checks++;
    if (sram_addr !== 18'd0) begin
      n_fail++; $display("FAIL reset_addr: got %h expected 0", sram_addr);
    end
    n_checks++;
    if (read_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_read_data: got %h expected 0", read_data);
    end
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 1", ready);
    end
    probe_en = 1; #1;
    n_checks++;
    if (sram_dq !== 16'hA5A5) begin
      n_fail++; $display("FAIL reset_dq_released: got %h expected a5a5", sram_dq);
    end
    probe_en = 0;
    rst = 0;
    tick();
  endtask

`ifdef SRAM_STALL_CNT_EN
  task automatic test_stall_cnt();
    rst = 1; #2;
    n_checks++;
    if (stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL stall_reset: got %0d expected 0", stall_cycles);
    end
    rst = 0;
    tick();
    for (int k = 0; k < 2; k++) begin
      rd_en = 1; address = 1024 + 32'(k * 4);
      repeat (2 * W + 1) tick();
      rd_en = 0;
      tick();
    end
    n_checks++;
    if (stall_cycles !== 32'd10) begin
      n_fail++; $display("FAIL stall_two_accesses: got %0d expected 10", stall_cycles);
    end
  endtask
`endif

  task automatic test_write();
    wr_en = 1; rd_en = 0; address = 1024 + 8; write_data = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++; $display("FAIL write_ready_c0: got %b expected 0", ready);
    end
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c <= 4) begin
        n_checks++;
        if (ready !== 1'b0) begin
          n_fail++; $display("FAIL write_ready_c%0d: got %b expected 0", c, ready);
        end
        n_checks++;
        if (sram_addr !== ((c <= 2) ? 18'd4 : 18'd5)) begin
          n_fail++; $display("FAIL write_addr_c%0d: got %0d expected %0d", c, sram_addr, (c <= 2) ? 4 : 5);
        end
        n_checks++;
        if (sram_dq !== ((c <= 2) ? 16'hBEEF : 16'hDEAD)) begin
          n_fail++; $display("FAIL write_dq_c%0d: got %h expected %h", c, sram_dq, (c <= 2) ? 16'hBEEF : 16'hDEAD);
        end
        n_checks++;
        if ({we_n, oe_n, ce_n, ub_n, lb_n} !== 5'b01000) begin
          n_fail++; $display("FAIL write_strobes_c%0d: got %b expected 01000", c, {we_n, oe_n, ce_n, ub_n, lb_n});
        end
      end else begin
        n_checks++;
        if (ready !== 1'b1) begin
          n_fail++; $display("FAIL write_ready_done: got %b expected 1", ready);
        end
        n_checks++;
        if (read_data !== 32'd0) begin
          n_fail++; $display("FAIL write_keeps_read_data: got %h expected 0", read_data);
        end
      end
    end
    wr_en = 0;
    ref_mem[4] = 16'hBEEF;
    ref_mem[5] = 16'hDEAD;
    tick();
    n_checks++;
    if (ce_n !== 1'b1) begin
      n_fail++; $display("FAIL write_idle_after: got ce_n=%b expected 1", ce_n);
    end
  endtask

  task automatic test_read();
    rd_en = 1; wr_en = 0; address = 1024 + 8;
    #1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c <= 4) begin
        n_checks++;
        if ({we_n, oe_n, ce_n} !== 3'b100) begin
          n_fail++; $display("FAIL read_strobes_c%0d: got %b expected 100", c, {we_n, oe_n, ce_n});
        end
      end else begin
        n_checks++;
        if (read_data !== 32'hDEADBEEF) begin
          n_fail++; $display("FAIL read_data_done: got %h expected deadbeef", read_data);
        end
      end
    end
    rd_en = 0;
    tick(); tick();
    n_checks++;
    if (read_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL read_data_held: got %h expected deadbeef", read_data);
    end
  endtask

  task automatic test_both();
    logic [31:0] prev, wd;
    prev = read_data;
    wd = $urandom;
    rd_en = 1; wr_en = 1; address = 1024 + 16; write_data = wd;
    #1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1 || c == 3) begin
        n_checks++;
        if ({we_n, oe_n} !== 2'b01) begin
          n_fail++; $display("FAIL both_is_write_c%0d: got %b expected 01", c, {we_n, oe_n});
        end
      end
    end
    n_checks++;
    if (read_data !== prev) begin
      n_fail++; $display("FAIL both_read_data_kept: got %h expected %h", read_data, prev);
    end
    rd_en = 0; wr_en = 0;
    ref_mem[8] = wd[15:0];
    ref_mem[9] = wd[31:16];
    tick();
  endtask

  task automatic test_drop();
    logic [31:0] exp;
    exp = {ref_half(9), ref_half(8)};
    rd_en = 1; wr_en = 0; address = 1024 + 16;
    #1;
    tick();
    rd_en = 0; address = $urandom;
    #1;
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++; $display("FAIL drop_ready: got %b expected 1", ready);
    end
    for (int c = 2; c <= 4; c++) begin
      tick();
      n_checks++;
      if (ce_n !== 1'b0 || sram_addr !== 18'(8 + (c - 1) / W)) begin
        n_fail++; $display("FAIL drop_continues_c%0d: got ce_n=%b addr=%0d expected 0 %0d", c, ce_n, sram_addr, 8 + (c - 1) / W);
      end
    end
    tick();
    n_checks++;
    if (read_data !== exp) begin
      n_fail++; $display("FAIL drop_read_data: got %h expected %h", read_data, exp);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_a, exp_b;
    logic        prev_ce, exp_rdy;
    int          n_start;
    exp_a = {ref_half(5), ref_half(4)};
    exp_b = {ref_half(7), ref_half(6)};
    rd_en = 1; wr_en = 0; address = 1024 + 8;
    #1;
    n_start = 0;
    prev_ce = ce_n;
    for (int c = 0; c <= 13; c++) begin
      if (c > 0) tick();
      exp_rdy = (c == 5) || (c >= 11);
      n_checks++;
      if (ready !== exp_rdy) begin
        n_fail++; $display("FAIL b2b_ready_c%0d: got %b expected %b", c, ready, exp_rdy);
      end
      if (prev_ce && !ce_n) n_start++;
      prev_ce = ce_n;
      if (c == 5) begin
        n_checks++;
        if (read_data !== exp_a) begin
          n_fail++; $display("FAIL b2b_first: got %h expected %h", read_data, exp_a);
        end
        address = 1024 + 12;
      end
      if (c == 11) begin
        n_checks++;
        if (read_data !== exp_b) begin
          n_fail++; $display("FAIL b2b_second: got %h expected %h", read_data, exp_b);
        end
        rd_en = 0;
      end
    end
    n_checks++;
    if (n_start !== 2) begin
      n_fail++; $display("FAIL b2b_access_count: got %0d expected 2", n_start);
    end
  endtask

  task automatic test_random();
    int          op, sel, hw, ph;
    bit          is_wr, is_rd;
    logic [31:0] a, wd, prev, exp_rd, exp_mid;
    logic [15:0] exp_dq;
    logic [1:0]  req;
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 3);
      is_wr = (op >= 2);
      is_rd = (op != 2);
      sel = $urandom_range(0, 3);
      if (sel == 0)      a = $urandom;
      else if (sel == 1) a = $urandom_range(0, 1023);
      else               a = 1024 + $urandom_range(0, 255);
      wd = $urandom;
      hw = hw_of(a);
      prev = read_data;
      exp_rd = is_wr ? prev : {ref_half(hw + 1), ref_half(hw)};
      exp_mid = is_wr ? prev : {prev[31:16], exp_rd[15:0]};
      rd_en = is_rd; wr_en = is_wr; address = a; write_data = wd;
      #1;
      n_checks++;
      if (ready !== 1'b0) begin
        n_fail++; $display("FAIL rnd%0d_ready_c0: got %b expected 0", n, ready);
      end
      for (int c = 1; c <= 2 * W + 1; c++) begin
        tick();
        if (c <= 2 * W) begin
          ph = (c - 1) / W;
          exp_dq = is_wr ? (ph == 1 ? wd[31:16] : wd[15:0]) : ref_half(hw + ph);
          n_checks++;
          if (ready !== 1'b0 || {ce_n, ub_n, lb_n} !== 3'b000) begin
            n_fail++; $display("FAIL rnd%0d_active_c%0d: got ready=%b ce/ub/lb=%b expected 0 000", n, c, ready, {ce_n, ub_n, lb_n});
          end
          n_checks++;
          if (sram_addr !== 18'(hw + ph)) begin
            n_fail++; $display("FAIL rnd%0d_addr_c%0d: got %h expected %h", n, c, sram_addr, 18'(hw + ph));
          end
          n_checks++;
          if (we_n !== !is_wr || oe_n !== is_wr) begin
            n_fail++; $display("FAIL rnd%0d_dir_c%0d: got we_n=%b oe_n=%b expected %b %b", n, c, we_n, oe_n, !is_wr, is_wr);
          end
          n_checks++;
          if (sram_dq !== exp_dq) begin
            n_fail++; $display("FAIL rnd%0d_dq_c%0d: got %h expected %h", n, c, sram_dq, exp_dq);
          end
          n_checks++;
          if (read_data !== (ph == 1 ? exp_mid : prev)) begin
            n_fail++; $display("FAIL rnd%0d_rdata_c%0d: got %h expected %h", n, c, read_data, ph == 1 ? exp_mid : prev);
          end
          // Inputs after acceptance must be ignored.
          address = $urandom; write_data = $urandom;
          req = 2'($urandom_range(1, 3));
          rd_en = req[0]; wr_en = req[1];
        end else begin
          n_checks++;
          if (ready !== 1'b1 || read_data !== exp_rd) begin
            n_fail++; $display("FAIL rnd%0d_done: got ready=%b data=%h expected 1 %h", n, ready, read_data, exp_rd);
          end
        end
      end
      if (is_wr) begin
        ref_mem[hw] = wd[15:0];
        ref_mem[hw + 1] = wd[31:16];
      end
      rd_en = 0; wr_en = 0;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    wr_en = 1; rd_en = 0; address = 1024 + 40; write_data = 32'h12345678;
    #1;
    repeat (3) tick();
    n_checks++;
    if (sram_addr !== 18'd21 || we_n !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_in_high: got addr=%0d we_n=%b expected 21 0", sram_addr, we_n);
    end
    rst = 1; wr_en = 0; probe_en = 1;
    #1;
    n_checks++;
    if ({we_n, oe_n, ce_n, ub_n, lb_n} !== 5'b11111) begin
      n_fail++; $display("FAIL rstmid_strobes: got %b expected 11111", {we_n, oe_n, ce_n, ub_n, lb_n});
    end
    n_checks++;
    if (sram_dq !== 16'hA5A5) begin
      n_fail++; $display("FAIL rstmid_dq_released: got %h expected a5a5", sram_dq);
    end
    n_checks++;
    if (read_data !== 32'd0) begin
      n_fail++; $display("FAIL rstmid_read_data: got %h expected 0", read_data);
    end
    probe_en = 0;
    ref_mem[20] = 16'h5678;
    tick();
    rst = 0;
    tick();
    rd_en = 1; address = 1024 + 8;
    #1;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) tick();
      n_checks++;
      if (ready !== (c == 5)) begin
        n_fail++; $display("FAIL rstmid_next_ready_c%0d: got %b expected %b", c, ready, c == 5);
      end
    end
    n_checks++;
    if (read_data !== {ref_half(5), ref_half(4)}) begin
      n_fail++; $display("FAIL rstmid_next_data: got %h expected %h", read_data, {ref_half(5), ref_half(4)});
    end
    rd_en = 0;
    tick();
  endtask

  initial begin
    rst = 1; rd_en = 0; wr_en = 0; address = 0; write_data = 0; probe_en = 0;
    test_reset();
`ifdef SRAM_STALL_CNT_EN
    test_stall_cnt();
    test_reset();
`endif
    test_write();
    test_read();
    test_both();
    test_drop();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
